hex_keypad_scan: RTL and testbench
==================================

HEX_KEYPAD_SCAN -- requirements
Module: hex_keypad_scan

Interface
REQ-001: Parameter SCAN_DIV, default 50000, gives clk cycles each column is driven (1 ms at 50 MHz); legal range 4 or more.
REQ-002: Parameter DEBOUNCE_SCANS, default 4, gives consecutive full scans needed to accept a press or a release; legal range 1 to 15.
REQ-003: Parameter REPEAT_SCANS, default 125, gives full scans between auto-repeat events; used only with the macro in REQ-025.
REQ-004: Port clk, input, 1 bit: the only clock; all logic SHALL be rising-edge.
REQ-005: Port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006: Port row, input, 4 bits: keypad row sense lines, active-low, pulled up externally.
REQ-007: Port col, output, 4 bits: keypad column drive, active-low, exactly one bit low at a time.
REQ-008: Port key_code, output, 4 bits: hex value of the last accepted key.
REQ-009: Port key_valid, output, 1 bit: one-cycle pulse marking a new accepted key event.
REQ-010: Port key_down, output, 1 bit: level, high while an accepted key is held.

Function
REQ-011: row SHALL pass through a 2-FF synchronizer before any use.
REQ-012: Column scan order SHALL be col = 1110, 1101, 1011, 0111, then wrap; each column is held for SCAN_DIV cycles.
REQ-013: Synchronized row SHALL be sampled on the last cycle of each column period; one full scan is 4 column periods.
REQ-014: Key map is code = MAP[r][c], where r is the row index and c the column index of the low bits.
- r0: 1 2 3 A
- r1: 4 5 6 B
- r2: 7 8 9 C
- r3: 0 F E D
REQ-015: Each full scan SHALL be classified at its end as NONE (no low sample), SINGLE(code) (exactly one low row/column sample), or MULTI (two or more).
REQ-016: The FSM SHALL have four states: IDLE, PRESS_DB, HELD and RELEASE_DB.
REQ-017: Transitions from IDLE and PRESS_DB:
- IDLE, on SINGLE(k): go to PRESS_DB, latch candidate k, set count to 1.
- PRESS_DB, on SINGLE(k) with k equal to the candidate: increment count.
- PRESS_DB, on SINGLE(other): restart with the new candidate, count 1.
- PRESS_DB, on NONE or MULTI: go to IDLE.
REQ-018: When count reaches DEBOUNCE_SCANS, the FSM SHALL go to HELD, load key_code with the candidate, set key_down to 1, and pulse key_valid in the same cycle.
- With DEBOUNCE_SCANS=1, the first SINGLE scan goes straight from IDLE to HELD.
REQ-019: Transitions from HELD and RELEASE_DB:
- HELD, on NONE: go to RELEASE_DB, count 1.
- HELD, on SINGLE(same) or MULTI: stay in HELD; a second key pressed while holding is ignored.
- HELD, on SINGLE(other): stay in HELD; no new event.
- RELEASE_DB, on NONE: increment count; at DEBOUNCE_SCANS go to IDLE and clear key_down.
- RELEASE_DB, on any non-NONE scan: return to HELD, with no event.
REQ-020: key_code SHALL hold its value after release until the next accepted key.
REQ-021: key_valid SHALL never be high on two consecutive cycles.

Reset
REQ-022: While reset_n is low, col SHALL be 1110, key_code 0000, key_valid 0, key_down 0, FSM in IDLE, and all counters and synchronizers cleared.
REQ-023: Assertion of reset_n mid-scan or mid-debounce SHALL take effect immediately and asynchronously; no pending event is emitted.
REQ-024: After reset_n rises, scanning SHALL restart at column 0 with a full SCAN_DIV period.

Configuration
REQ-025: With macro KEYPAD_AUTOREPEAT_EN defined, HELD SHALL re-pulse key_valid with an unchanged key_code after every REPEAT_SCANS full scans held; the repeat counter is cleared on entry to HELD and paused in RELEASE_DB.
REQ-026: Without KEYPAD_AUTOREPEAT_EN, key_valid SHALL pulse exactly once per accepted press, and no repeat counter is synthesized.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=2, REPEAT_SCANS=3)
REQ-027: Reset check: hold reset_n low with row=0000 -> col=1110, key_code=0, key_valid=0, key_down=0; release reset_n -> col steps to 1101 after 4 cycles.
REQ-028: Clean press: model key "9" (row2 pulled low while col=1011) for 3 full scans -> exactly one key_valid pulse at the end of scan 2, key_code=9, key_down=1.
REQ-029: Bounce: key "5" present in one scan, absent in the next, then present in 2 scans -> no event after the first scan, one event with key_code=5 after the 2 stable scans.
REQ-030: Two keys: keys "1" and "E" held together from IDLE -> no key_valid pulse and key_down stays 0; holding "1" and adding "E" while in HELD -> key_code stays 1 with no new event.
REQ-031: Release and reset: after "A" is accepted, release for 1 scan then press again -> no new event; assert reset_n mid-scan -> all outputs return to reset values immediately.
REQ-032: With KEYPAD_AUTOREPEAT_EN, hold "F" for 11 scans -> key_valid pulses at the end of scans 2, 5, 8 and 11; without the macro, exactly one pulse.

Source files
------------

// File: rtl/hex_keypad_scan.sv
// 4x4 hex keypad scanner: column drive, row synchronizer, per-scan classification and
// press/release debounce FSM. Define KEYPAD_AUTOREPEAT_EN to re-pulse key_valid while held.
module hex_keypad_scan #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 125
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int            DW       = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic [3:0]    DB_N     = 4'(DEBOUNCE_SCANS);

    generate
        if (SCAN_DIV < 4) begin : g_bad_div
            $error("SCAN_DIV must be 4 or more");
        end
        if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : g_bad_db
            $error("DEBOUNCE_SCANS must be 1 to 15");
        end
        if (REPEAT_SCANS < 1) begin : g_bad_rep
            $error("REPEAT_SCANS must be 1 or more");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        key_map = 4'h0;
        case ({r, c})
            4'h0: key_map = 4'h1;
            4'h1: key_map = 4'h2;
            4'h2: key_map = 4'h3;
            4'h3: key_map = 4'hA;
            4'h4: key_map = 4'h4;
            4'h5: key_map = 4'h5;
            4'h6: key_map = 4'h6;
            4'h7: key_map = 4'hB;
            4'h8: key_map = 4'h7;
            4'h9: key_map = 4'h8;
            4'hA: key_map = 4'h9;
            4'hB: key_map = 4'hC;
            4'hC: key_map = 4'h0;
            4'hD: key_map = 4'hF;
            4'hE: key_map = 4'hE;
            4'hF: key_map = 4'hD;
            default: key_map = 4'h0;
        endcase
    endfunction

    // Synchronizer idles at all-ones, matching the pulled-up (no key) row level.
    logic [3:0] row_meta_reg, row_sync_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_meta_reg <= 4'hF;
            row_sync_reg <= 4'hF;
        end else begin
            row_meta_reg <= row;
            row_sync_reg <= row_meta_reg;
        end
    end

    logic [DW-1:0] div_reg;
    logic [1:0]    col_idx_reg;
    logic          col_end, scan_end;

    assign col_end  = (div_reg == DIV_LAST);
    assign scan_end = col_end && (col_idx_reg == 2'd3);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_reg     <= '0;
            col_idx_reg <= 2'd0;
        end else if (col_end) begin
            div_reg     <= '0;
            col_idx_reg <= col_idx_reg + 2'd1;
        end else begin
            div_reg <= div_reg + DIV_ONE;
        end
    end

    logic [3:0] hit;
    logic [3:0] row_code [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign col[gi]      = (col_idx_reg != 2'(gi));
        assign hit[gi]      = ~row_sync_reg[gi];
        assign row_code[gi] = key_map(2'(gi), col_idx_reg);
    end

    // Running tally of low samples in the current scan, saturating at 2 (= MULTI).
    logic [1:0] acc_cnt_reg;
    logic [3:0] acc_code_reg;
    logic [1:0] col_cnt, tot_cnt;
    logic [2:0] tot_sum;
    logic [3:0] col_code, tot_code;
    logic       scan_none, scan_single;

    always_comb begin
        col_cnt  = 2'd0;
        col_code = 4'h0;
        for (int r = 0; r < 4; r++) begin
            if (hit[r]) begin
                col_code = row_code[r];
                if (col_cnt != 2'd2) col_cnt = col_cnt + 2'd1;
            end
        end
        tot_sum  = 3'(acc_cnt_reg) + 3'(col_cnt);
        tot_cnt  = (tot_sum >= 3'd2) ? 2'd2 : tot_sum[1:0];
        tot_code = (acc_cnt_reg == 2'd0) ? col_code : acc_code_reg;
    end

    assign scan_none   = (tot_cnt == 2'd0);
    assign scan_single = (tot_cnt == 2'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_cnt_reg  <= 2'd0;
            acc_code_reg <= 4'h0;
        end else if (col_end) begin
            acc_cnt_reg  <= scan_end ? 2'd0 : tot_cnt;
            acc_code_reg <= scan_end ? 4'h0 : tot_code;
        end
    end

    state_t     state_reg, state_next;
    logic [3:0] cand_reg, cand_next;
    logic [3:0] cnt_reg, cnt_next;
    logic [3:0] key_code_reg, key_code_next;
    logic       key_valid_reg, key_valid_next;
    logic       key_down_reg, key_down_next;
    logic       accept;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int            RW      = $clog2(REPEAT_SCANS + 1);
    localparam logic [RW-1:0] REP_N   = RW'(REPEAT_SCANS);
    localparam logic [RW-1:0] REP_ONE = RW'(1);
    logic [RW-1:0] rep_reg, rep_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rep_reg <= '0;
        else          rep_reg <= rep_next;
    end
`endif

    always_comb begin
        state_next     = state_reg;
        cand_next      = cand_reg;
        cnt_next       = cnt_reg;
        key_code_next  = key_code_reg;
        key_down_next  = key_down_reg;
        key_valid_next = 1'b0;
        accept         = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_next       = rep_reg;
`endif
        if (scan_end) begin
            case (state_reg)
                IDLE: begin
                    if (scan_single) begin
                        cand_next = tot_code;
                        cnt_next  = 4'd1;
                        if (DB_N == 4'd1) accept = 1'b1;
                        else              state_next = PRESS_DB;
                    end
                end
                PRESS_DB: begin
                    if (!scan_single) begin
                        state_next = IDLE;
                    end else if (tot_code != cand_reg) begin
                        cand_next = tot_code;
                        cnt_next  = 4'd1;
                    end else if (cnt_reg + 4'd1 == DB_N) begin
                        accept = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 4'd1;
                    end
                end
                HELD: begin
                    if (scan_none) begin
                        if (DB_N == 4'd1) begin
                            state_next    = IDLE;
                            key_down_next = 1'b0;
                        end else begin
                            state_next = RELEASE_DB;
                            cnt_next   = 4'd1;
                        end
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    else if (rep_reg + REP_ONE == REP_N) begin
                        rep_next       = '0;
                        key_valid_next = 1'b1;
                    end else begin
                        rep_next = rep_reg + REP_ONE;
                    end
`endif
                end
                RELEASE_DB: begin
                    if (!scan_none) begin
                        state_next = HELD;
                    end else if (cnt_reg + 4'd1 == DB_N) begin
                        state_next    = IDLE;
                        key_down_next = 1'b0;
                    end else begin
                        cnt_next = cnt_reg + 4'd1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
        if (accept) begin
            state_next     = HELD;
            key_code_next  = tot_code;
            key_down_next  = 1'b1;
            key_valid_next = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_next       = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            cand_reg      <= 4'h0;
            cnt_reg       <= 4'd0;
            key_code_reg  <= 4'h0;
            key_valid_reg <= 1'b0;
            key_down_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cand_reg      <= cand_next;
            cnt_reg       <= cnt_next;
            key_code_reg  <= key_code_next;
            key_valid_reg <= key_valid_next;
            key_down_reg  <= key_down_next;
        end
    end

    assign key_code  = key_code_reg;
    assign key_valid = key_valid_reg;
    assign key_down  = key_down_reg;

endmodule

// File: tb/tb_hex_keypad_scan.sv
// Directed bench for hex_keypad_scan with a behavioural keypad matrix model.
// Follows KEYPAD_AUTOREPEAT_EN to pick the expected repeat behaviour.
module tb_hex_keypad_scan;

    localparam int SD = 4;
    localparam int DB = 2;
    localparam int RS = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] row, col, key_code;
    logic       key_valid, key_down;
    logic [15:0] pressed = 16'h0;
    logic       force_low = 1'b1;
    logic       prev_valid = 1'b0;
    int         checks = 0;
    int         errors = 0;
    int         vcount = 0;
    int         v0;
    logic       exp_v;

    always #5 clk = ~clk;

    hex_keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB), .REPEAT_SCANS(RS)) dut (
        .clk(clk), .reset_n(reset_n), .row(row), .col(col),
        .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
    );

    function automatic int key_at(input int r, input int c);
        case (r * 4 + c)
            0: key_at = 1;   1: key_at = 2;   2: key_at = 3;   3: key_at = 10;
            4: key_at = 4;   5: key_at = 5;   6: key_at = 6;   7: key_at = 11;
            8: key_at = 7;   9: key_at = 8;   10: key_at = 9;  11: key_at = 12;
            12: key_at = 0;  13: key_at = 15; 14: key_at = 14; default: key_at = 13;
        endcase
    endfunction

    // A pressed key shorts its row to its column while that column is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!col[c] && pressed[key_at(r, c)]) row[r] = 1'b0;
        if (force_low) row = 4'h0;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) begin
            $display("check %s got %0h", tag, got);
        end else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        if (reset_n && key_valid) begin
            vcount++;
            check("valid_not_consecutive", {15'd0, prev_valid}, 16'd0);
        end
        prev_valid = reset_n && key_valid;
    end

    task automatic scan();
        repeat (4 * SD) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with rows forced low
        repeat (3) @(posedge clk);
        #1;
        check("rst_col", {12'd0, col}, 16'hE);
        check("rst_code", {12'd0, key_code}, 16'h0);
        check("rst_valid", {15'd0, key_valid}, 16'h0);
        check("rst_down", {15'd0, key_down}, 16'h0);
        @(negedge clk);
        reset_n = 1'b1;
        force_low = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("col0_held", {12'd0, col}, 16'hE);
        @(posedge clk);
        #1;
        check("col1_step", {12'd0, col}, 16'hD);
        repeat (12) @(posedge clk);
        #1;

        // Clean press of 9
        v0 = vcount;
        pressed = 16'h0200;
        scan();
        check("p9_s1_valid", {15'd0, key_valid}, 16'h0);
        check("p9_s1_down", {15'd0, key_down}, 16'h0);
        scan();
        check("p9_s2_valid", {15'd0, key_valid}, 16'h1);
        check("p9_s2_code", {12'd0, key_code}, 16'h9);
        check("p9_s2_down", {15'd0, key_down}, 16'h1);
        scan();
        check("p9_s3_valid", {15'd0, key_valid}, 16'h0);
        check("p9_s3_down", {15'd0, key_down}, 16'h1);
        pressed = 16'h0;
        scan();
        check("p9_rel1_down", {15'd0, key_down}, 16'h1);
        scan();
        check("p9_rel2_down", {15'd0, key_down}, 16'h0);
        check("p9_code_kept", {12'd0, key_code}, 16'h9);
        check("p9_pulses", 16'(vcount - v0), 16'd1);

        // Bounce on 5
        pressed = 16'h0020;
        scan();
        check("b5_s1_valid", {15'd0, key_valid}, 16'h0);
        pressed = 16'h0;
        scan();
        check("b5_gap_valid", {15'd0, key_valid}, 16'h0);
        pressed = 16'h0020;
        scan();
        check("b5_s3_valid", {15'd0, key_valid}, 16'h0);
        scan();
        check("b5_s4_valid", {15'd0, key_valid}, 16'h1);
        check("b5_s4_code", {12'd0, key_code}, 16'h5);
        pressed = 16'h0;
        scan();
        scan();
        check("b5_rel_down", {15'd0, key_down}, 16'h0);

        // Keys 1 and E together from IDLE, then E added while 1 is held
        v0 = vcount;
        pressed = 16'h4002;
        for (int s = 0; s < 3; s++) begin
            scan();
            check("multi_valid", {15'd0, key_valid}, 16'h0);
            check("multi_down", {15'd0, key_down}, 16'h0);
        end
        check("multi_pulses", 16'(vcount - v0), 16'd0);
        pressed = 16'h0;
        scan();
        pressed = 16'h0002;
        scan();
        scan();
        check("k1_valid", {15'd0, key_valid}, 16'h1);
        check("k1_code", {12'd0, key_code}, 16'h1);
        pressed = 16'h4002;
        for (int s = 0; s < 2; s++) begin
            scan();
            check("k1e_valid", {15'd0, key_valid}, 16'h0);
            check("k1e_code", {12'd0, key_code}, 16'h1);
            check("k1e_down", {15'd0, key_down}, 16'h1);
        end
        pressed = 16'h0;
        scan();
        scan();
        check("k1e_rel_down", {15'd0, key_down}, 16'h0);

        // A accepted, short release, press again, then asynchronous reset mid-scan
        pressed = 16'h0400;
        scan();
        scan();
        check("kA_valid", {15'd0, key_valid}, 16'h1);
        check("kA_code", {12'd0, key_code}, 16'hA);
        pressed = 16'h0;
        scan();
        check("kA_gap_down", {15'd0, key_down}, 16'h1);
        check("kA_gap_valid", {15'd0, key_valid}, 16'h0);
        pressed = 16'h0400;
        scan();
        check("kA_back_valid", {15'd0, key_valid}, 16'h0);
        check("kA_back_down", {15'd0, key_down}, 16'h1);
        repeat (5) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_col", {12'd0, col}, 16'hE);
        check("arst_code", {12'd0, key_code}, 16'h0);
        check("arst_valid", {15'd0, key_valid}, 16'h0);
        check("arst_down", {15'd0, key_down}, 16'h0);
        pressed = 16'h0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4 * SD) @(posedge clk);
        #1;

        // Hold F for 11 scans
        v0 = vcount;
        pressed = 16'h8000;
        for (int s = 1; s <= 11; s++) begin
            scan();
`ifdef KEYPAD_AUTOREPEAT_EN
            exp_v = (s % 3 == 2);
`else
            exp_v = (s == 2);
`endif
            check("hold_f_valid", {15'd0, key_valid}, {15'd0, exp_v});
        end
        check("hold_f_code", {12'd0, key_code}, 16'hF);
        pressed = 16'h0;
        scan();
        scan();
`ifdef KEYPAD_AUTOREPEAT_EN
        check("hold_f_pulses", 16'(vcount - v0), 16'd4);
`else
        check("hold_f_pulses", 16'(vcount - v0), 16'd1);
`endif
        check("hold_f_rel_down", {15'd0, key_down}, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
